// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Contents:
//   state_e - FSM encoding (IDLE: no grant, BUSY: exactly one grant bit set)
//   idx_w   - width of a binary index into n requesters (minimum 1 bit)
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Bus bundle between the requesters and the mux arbiter.
// Signals:
//   req       - per-requester request, level-held
//   din       - flattened data, requester i at [i*WIDTH +: WIDTH]
//   grant     - one-hot grant (registered in the arbiter)
//   sel       - binary index of the granted requester
//   out       - registered mux output
//   out_valid - out holds data from a granted cycle
// Modports: master drives req/din, slave (the arbiter) drives the rest.
interface mux_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din;
  logic [N_REQ-1:0]       grant;
  logic [IW-1:0]          sel;
  logic [WIDTH-1:0]       out;
  logic                   out_valid;

  modport master (
    output req, din,
    input  grant, sel, out, out_valid
  );

  modport slave (
    input  req, din,
    output grant, sel, out, out_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - candidate request vector
//   start_i - index where the search begins (wraps modulo N_REQ)
//   grant_o - one-hot winner (all zero when no candidate)
//   idx_o   - binary index of the winner (zero when no candidate)
//   any_o   - at least one candidate present
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    start_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int pos;

  // Scan requesters from start_i upward with wrap; first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (int'(start_i) + k) % N_REQ;
      if (!any_o && req_i[pos]) begin
        any_o        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = IW'(pos);
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a registered data mux.
// Ports:
//   clk - single clock, all state on the rising edge
//   rst - synchronous active-high reset, dominates all inputs
//   bus - mux_arbiter_if slave modport (req/din in; grant/sel/out/out_valid out)
// A holder keeps its grant while it requests and has held fewer than
// MAX_HOLD cycles; at MAX_HOLD it yields only if someone else is waiting.
// All outputs come straight from flops.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  mux_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [IW-1:0]    last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [N_REQ-1:0] cand_s;
  logic [N_REQ-1:0] pick_oh_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic             holder_req_s;

  // The current holder is never a candidate: on a drop its req is low
  // anyway, and at MAX_HOLD it must be excluded. A sole holder at MAX_HOLD
  // leaves no candidates and therefore keeps the grant.
  assign cand_s       = bus.req & ~grant_q;
  assign holder_req_s = (state_q == BUSY) & bus.req[sel_q];

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i   (cand_s),
    .start_i (last_q + IW'(1)),
    .grant_o (pick_oh_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  // Next-state decision for grant, hold counter, pointer and data path.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    out_valid_d = |grant_q;
    out_d       = out_q;
    if (|grant_q) begin
      out_d = bus.din[int'(sel_q)*WIDTH +: WIDTH];
    end else begin
      out_d = out_q;
    end

    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = BUSY;
          grant_d = pick_oh_s;
          sel_d   = pick_idx_s;
          last_d  = pick_idx_s;
          hold_d  = HW'(1);
        end else begin
          grant_d = '0;
          sel_d   = '0;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (holder_req_s && ((hold_q < HW'(MAX_HOLD)) || !pick_any_s)) begin
          hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);
        end else if (pick_any_s) begin
          grant_d = pick_oh_s;
          sel_d   = pick_idx_s;
          last_d  = pick_idx_s;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // FSM and output registers; reset points last_q at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= IW'(N_REQ - 1);
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
